sum_accumulator: RTL and testbench

//   Downstream consumer of the FourBitAdder sum. Accepts one IN_W-bit sum per handshake
//   and adds it into an ACC_W-bit running total. After COUNT_N accepted sums it presents
//   the frame total and a sticky overflow flag, holds them until taken, then starts a new frame.

---
 rtl/sum_accumulator.sv | 106 ++++++++++
 tb/tb_sum_accumulator.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums COUNT_N incoming adder results, then holds the total until taken.
// Optional SUM_ACC_SATURATE_EN clamps the total at all-ones on carry out instead of wrapping.
//
// state | meaning
// ACCUM | accepting sums, out_acc shows the partial total
// HOLD  | frame complete, out_acc/out_ovf held until out_ready
module sum_accumulator #(
    parameter int IN_W    = 5,
    parameter int ACC_W   = 8,
    parameter int COUNT_N = 4,
    localparam int CW     = $clog2(COUNT_N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [CW-1:0]    count
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [CW-1:0] LAST = CW'(COUNT_N - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [ACC_W:0]   sum_wide;
    logic             accept;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        accept      = in_valid & in_ready_q;
        sum_wide    = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_sum};

        if (clear) begin
            state_d     = ACCUM;
            acc_d       = '0;
            ovf_d       = 1'b0;
            count_d     = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end else if (state_q == HOLD) begin
            if (out_valid_q && out_ready) begin
                state_d     = ACCUM;
                acc_d       = '0;
                ovf_d       = 1'b0;
                count_d     = '0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        end else if (accept) begin
`ifdef SUM_ACC_SATURATE_EN
            // Once saturated, any further carry keeps the total pinned at all-ones.
            acc_d = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
            acc_d = sum_wide[ACC_W-1:0];
`endif
            ovf_d   = ovf_q | sum_wide[ACC_W];
            count_d = count_q + CW'(1);
            if (count_q == LAST) begin
                state_d     = HOLD;
                out_valid_d = 1'b1;
                in_ready_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;
    assign count     = count_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: 8-bit and 6-bit instances share stimulus.
// Expectations for the 6-bit instance follow SUM_ACC_SATURATE_EN when it is defined.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       reset, clear, in_valid, out_ready;
    logic [4:0] in_sum;

    logic       in_ready8, out_valid8, out_ovf8;
    logic [7:0] out_acc8;
    logic [2:0] count8;
    logic       in_ready6, out_valid6, out_ovf6;
    logic [5:0] out_acc6;
    logic [2:0] count6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.IN_W(5), .ACC_W(8), .COUNT_N(4)) dut8 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
        .in_sum(in_sum), .out_valid(out_valid8), .out_ready(out_ready), .out_acc(out_acc8),
        .out_ovf(out_ovf8), .count(count8));

    sum_accumulator #(.IN_W(5), .ACC_W(6), .COUNT_N(4)) dut6 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready6),
        .in_sum(in_sum), .out_valid(out_valid6), .out_ready(out_ready), .out_acc(out_acc6),
        .out_ovf(out_ovf6), .count(count6));

    typedef struct {
        logic [4:0] s0, s1, s2, s3;
        logic [7:0] acc8;
        logic       ovf8;
        logic [5:0] acc6_wrap;
        logic [5:0] acc6_sat;
        logic       ovf6;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high so consecutive calls are back-to-back accepts.
    task automatic accept_one(input logic [4:0] s, input logic [2:0] exp_count);
        in_valid = 1'b1;
        in_sum   = s;
        check("in_ready_before_accept", {31'b0, in_ready8}, 1);
        tick();
        check("count_after_accept", {29'b0, count8}, {29'b0, exp_count});
        check("count6_after_accept", {29'b0, count6}, {29'b0, exp_count});
    endtask

    function automatic logic [5:0] exp6(input vec_t v);
`ifdef SUM_ACC_SATURATE_EN
        return v.acc6_sat;
`else
        return v.acc6_wrap;
`endif
    endfunction

    initial begin
        vecs[0] = '{s0: 5,  s1: 10, s2: 15, s3: 20, acc8: 50,  ovf8: 0, acc6_wrap: 50, acc6_sat: 50, ovf6: 0};
        vecs[1] = '{s0: 31, s1: 31, s2: 31, s3: 31, acc8: 124, ovf8: 0, acc6_wrap: 60, acc6_sat: 63, ovf6: 1};
        vecs[2] = '{s0: 0,  s1: 0,  s2: 0,  s3: 0,  acc8: 0,   ovf8: 0, acc6_wrap: 0,  acc6_sat: 0,  ovf6: 0};
        vecs[3] = '{s0: 17, s1: 30, s2: 25, s3: 8,  acc8: 80,  ovf8: 0, acc6_wrap: 16, acc6_sat: 63, ovf6: 1};

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0;
        tick(); tick();
        reset = 1'b0;
        check("reset_out_valid", {31'b0, out_valid8}, 0);
        check("reset_in_ready", {31'b0, in_ready8}, 1);
        check("reset_out_acc", {24'b0, out_acc8}, 0);
        check("reset_out_ovf", {31'b0, out_ovf8}, 0);
        check("reset_count", {29'b0, count8}, 0);

        // Back-to-back frames with downstream always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            accept_one(vecs[i].s0, 3'd1);
            check("partial_acc", {24'b0, out_acc8}, {27'b0, vecs[i].s0});
            check("partial_valid", {31'b0, out_valid8}, 0);
            accept_one(vecs[i].s1, 3'd2);
            accept_one(vecs[i].s2, 3'd3);
            accept_one(vecs[i].s3, 3'd4);
            in_valid = 1'b0;
            check("frame_out_valid", {31'b0, out_valid8}, 1);
            check("frame_in_ready", {31'b0, in_ready8}, 0);
            check("frame_acc8", {24'b0, out_acc8}, {24'b0, vecs[i].acc8});
            check("frame_ovf8", {31'b0, out_ovf8}, {31'b0, vecs[i].ovf8});
            check("frame_acc6", {26'b0, out_acc6}, {26'b0, exp6(vecs[i])});
            check("frame_ovf6", {31'b0, out_ovf6}, {31'b0, vecs[i].ovf6});
            tick();
            check("post_frame_valid", {31'b0, out_valid8}, 0);
            check("post_frame_in_ready", {31'b0, in_ready8}, 1);
            check("post_frame_acc", {24'b0, out_acc8}, 0);
            check("post_frame_ovf6", {31'b0, out_ovf6}, 0);
            check("post_frame_count", {29'b0, count8}, 0);
        end

        // Backpressure: HOLD ignores in_valid while out_ready is low.
        out_ready = 1'b0;
        accept_one(5, 3'd1); accept_one(10, 3'd2); accept_one(15, 3'd3); accept_one(20, 3'd4);
        in_sum = 7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_out_valid", {31'b0, out_valid8}, 1);
            check("bp_out_acc", {24'b0, out_acc8}, 50);
            check("bp_in_ready", {31'b0, in_ready8}, 0);
            check("bp_count", {29'b0, count8}, 4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", {31'b0, out_valid8}, 0);
        check("bp_release_acc", {24'b0, out_acc8}, 0);
        check("bp_release_count", {29'b0, count8}, 0);

        // Clear mid-frame, then a fresh frame.
        accept_one(9, 3'd1); accept_one(9, 3'd2);
        in_valid = 1'b0;
        check("pre_clear_acc", {24'b0, out_acc8}, 18);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_count", {29'b0, count8}, 0);
        check("clear_acc", {24'b0, out_acc8}, 0);
        accept_one(1, 3'd1); accept_one(1, 3'd2); accept_one(1, 3'd3); accept_one(1, 3'd4);
        in_valid = 1'b0;
        check("clear_frame_valid", {31'b0, out_valid8}, 1);
        check("clear_frame_acc", {24'b0, out_acc8}, 4);
        check("clear_frame_ovf", {31'b0, out_ovf8}, 0);
        tick();

        // Clear on the completing accept discards the frame.
        accept_one(3, 3'd1); accept_one(3, 3'd2); accept_one(3, 3'd3);
        in_sum = 3;
        clear  = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_done_valid", {31'b0, out_valid8}, 0);
        check("clr_done_count", {29'b0, count8}, 0);
        check("clr_done_acc", {24'b0, out_acc8}, 0);
        check("clr_done_in_ready", {31'b0, in_ready8}, 1);

        // Reset while holding an overflowed frame.
        out_ready = 1'b0;
        accept_one(31, 3'd1); accept_one(31, 3'd2); accept_one(31, 3'd3); accept_one(31, 3'd4);
        in_valid = 1'b0;
        check("hold_ovf6", {31'b0, out_ovf6}, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_hold_valid", {31'b0, out_valid8}, 0);
        check("rst_hold_in_ready", {31'b0, in_ready8}, 1);
        check("rst_hold_acc", {24'b0, out_acc8}, 0);
        check("rst_hold_ovf6", {31'b0, out_ovf6}, 0);
        check("rst_hold_count", {29'b0, count8}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
